ex_madd_seq: RTL and testbench

Execute-stage sequencer for MADD, MADDU, MSUB and MSUBU. It multiplies the two operands, then adds the product to HI/LO or subtracts it from HI/LO. Multi-cycle state is carried through the EX/MEM register's temporary-result loop: the block drives hilo_temp_o/cnt_o forward and reads them back as hilo_temp_i/cnt_i. It requests a pipeline stall until the accumulated HI/LO value is ready to advance to MEM.

---
 rtl/ex_madd_seq.sv | 217 +++++++++++++++++++++
 tb/tb_ex_madd_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ex_madd_seq.sv
// ex_madd_seq -- execute-stage sequencer for MADD / MADDU / MSUB / MSUBU.
//
// Multiplies reg1_i by reg2_i and adds the product to, or subtracts it from,
// {hi_i, lo_i}. Multi-cycle state travels through the EX/MEM temporary-result
// loop: the product and a phase count are driven out on hilo_temp_o/cnt_o and
// come back one cycle later on hilo_temp_i/cnt_i. stallreq_o holds the pipe
// until the accumulated HI/LO value is ready to move on to MEM.
//
// Build option: define MADD_FAST_MUL_EN to replace the 4-cycle byte-serial
// multiplier with a single-cycle combinational 32x32 product (2 cycles total).
// Both builds give bit-identical results.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_i         abort the in-flight operation; all outputs 0 this cycle
//   aluop_i         decoded ALU op
//   reg1_i, reg2_i  multiplicand (rs), multiplier (rt)
//   hi_i, lo_i      current HI/LO (forwarded), sampled in the ACC phase
//   hilo_temp_i     product returned from EX/MEM
//   cnt_i           phase count returned from EX/MEM
//   hilo_temp_o     signed product sent to EX/MEM
//   cnt_o           phase count sent to EX/MEM
//   stallreq_o      stall request to the pipeline controller
//   whilo_o         HI/LO write enable
//   hi_o, lo_o      new HI/LO
module ex_madd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [63:0] hilo_temp_i,
  input  logic [1:0]  cnt_i,
  output logic [63:0] hilo_temp_o,
  output logic [1:0]  cnt_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  localparam logic [1:0] S_IDLE = 2'd0;
`ifndef MADD_FAST_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_PROD = 2'd2;
`endif
  localparam logic [1:0] S_ACC  = 2'd3;

  // Two's-complement magnitude; 0x80000000 maps to itself and is read unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] apply_sign(input logic [63:0] p, input logic neg);
    return neg ? (~p + 64'd1) : p;
  endfunction

  // Operand decode, shared by the latch in IDLE and the fast product.
  logic        is_madd;
  logic        op_signed;
  logic        op_sub;
  logic        in_neg;
  logic [31:0] in_abs_a;
  logic [31:0] in_abs_b;

  always_comb begin
    is_madd   = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
                (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    op_signed = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);
    op_sub    = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    in_neg    = (op_signed & (reg1_i[31] ^ reg2_i[31])) ^ op_sub;
    in_abs_a  = magnitude(reg1_i, op_signed);
    in_abs_b  = magnitude(reg2_i, op_signed);
  end

  logic [1:0] state_q, state_d;

`ifdef MADD_FAST_MUL_EN
  logic [63:0] fast_prod;

  always_comb begin
    fast_prod = {32'd0, in_abs_a} * {32'd0, in_abs_b};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (is_madd) state_d = S_ACC;
      S_ACC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end
`else
  logic [1:0]  k_q, k_d;
  logic [31:0] abs_a_q, abs_a_d;
  logic [31:0] abs_b_q, abs_b_d;
  logic        neg_q, neg_d;
  logic [63:0] prod_q, prod_d;
  logic [63:0] partial;

  // One byte of the multiplier per cycle, weighted by its byte position.
  always_comb begin
    partial = ({32'd0, abs_a_q} * {56'd0, abs_b_q[{k_q, 3'b000} +: 8]}) << {k_q, 3'b000};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    abs_a_d = abs_a_q;
    abs_b_d = abs_b_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (is_madd) begin
          abs_a_d = in_abs_a;
          abs_b_d = in_abs_b;
          neg_d   = in_neg;
          prod_d  = 64'd0;
          k_d     = 2'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        prod_d = prod_q + partial;
        k_d    = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_PROD;
      end
      S_PROD:  state_d = S_ACC;
      S_ACC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk) begin
    abs_a_q <= abs_a_d;
    abs_b_q <= abs_b_d;
    neg_q   <= neg_d;
    prod_q  <= prod_d;
  end
`endif

  logic [63:0] acc_sum;

  always_comb begin
    acc_sum     = {hi_i, lo_i} + hilo_temp_i;
    hilo_temp_o = 64'd0;
    cnt_o       = 2'b00;
    stallreq_o  = 1'b0;
    whilo_o     = 1'b0;
    hi_o        = 32'd0;
    lo_o        = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (is_madd) begin
          stallreq_o = 1'b1;
`ifdef MADD_FAST_MUL_EN
          hilo_temp_o = apply_sign(fast_prod, in_neg);
          cnt_o       = 2'b01;
`endif
        end
      end
`ifndef MADD_FAST_MUL_EN
      S_MUL: stallreq_o = 1'b1;
      S_PROD: begin
        hilo_temp_o = apply_sign(prod_q, neg_q);
        cnt_o       = 2'b01;
        stallreq_o  = 1'b1;
      end
`endif
      S_ACC: begin
        // A count other than 01 means EX/MEM did not hold the product; drop the op.
        if (cnt_i == 2'b01) begin
          hi_o    = acc_sum[63:32];
          lo_o    = acc_sum[31:0];
          whilo_o = 1'b1;
          cnt_o   = 2'b10;
        end
      end
      default: ;
    endcase
    if (flush_i) begin
      hilo_temp_o = 64'd0;
      cnt_o       = 2'b00;
      stallreq_o  = 1'b0;
      whilo_o     = 1'b0;
      hi_o        = 32'd0;
      lo_o        = 32'd0;
    end
  end

endmodule

// File: tb/tb_ex_madd_seq.sv
module tb_ex_madd_seq;

  localparam logic [7:0] NOP_OP       = 8'h00;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

`ifdef MADD_FAST_MUL_EN
  localparam int EXP_STALL = 1;
`else
  localparam int EXP_STALL = 6;
`endif

  logic        clk = 1'b0;
  logic        rst, flush_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
  logic        stallreq_o, whilo_o;
  logic [31:0] hi_o, lo_o;

  int passed = 0;
  int total  = 0;
  int stalls;
  logic [63:0] temp;

  ex_madd_seq dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .hi_i(hi_i), .lo_i(lo_i),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o), .stallreq_o(stallreq_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock; models the EX/MEM loop: hold the driven temp/count while the
  // pipe is stalled, reload zero when it advances.
  task automatic tick();
    logic [63:0] h;
    logic [1:0]  c;
    logic        s;
    #1;
    h = hilo_temp_o;
    c = cnt_o;
    s = stallreq_o;
    @(posedge clk);
    #1;
    if (s) begin
      hilo_temp_i = h;
      cnt_i       = c;
    end else begin
      hilo_temp_i = 64'd0;
      cnt_i       = 2'b00;
    end
    #1;
  endtask

  task automatic start_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l);
    aluop_i = op;
    reg1_i  = a;
    reg2_i  = b;
    hi_i    = h;
    lo_i    = l;
    #1;
  endtask

  // Advance while stalled; returns the number of stall cycles and the last
  // product seen with cnt_o==01.
  task automatic run_to_acc(output int n, output logic [63:0] t);
    n = 0;
    t = 64'd0;
    while (stallreq_o === 1'b1 && n < 20) begin
      n++;
      if (cnt_o === 2'b01) t = hilo_temp_o;
      tick();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stall"}, {63'd0, stallreq_o}, 64'd0);
    chk({tag, ".whilo"}, {63'd0, whilo_o}, 64'd0);
    chk({tag, ".cnt"},   {62'd0, cnt_o}, 64'd0);
    chk({tag, ".hilo"},  {hi_o, lo_o} | hilo_temp_o, 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; aluop_i = NOP_OP;
    reg1_i = '0; reg2_i = '0; hi_i = '0; lo_i = '0;
    hilo_temp_i = '0; cnt_i = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_zero("reset");

    // MADD 3 * -2 + 10 = 4
    start_op(EXE_MADD_OP, 32'd3, 32'hFFFF_FFFE, 32'd0, 32'd10);
    chk("s1.t0_stall", {63'd0, stallreq_o}, 64'd1);
    run_to_acc(stalls, temp);
    chk("s1.stall_cycles", 64'(stalls), 64'(EXP_STALL));
    chk("s1.temp", temp, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("s1.whilo", {63'd0, whilo_o}, 64'd1);
    chk("s1.hilo", {hi_o, lo_o}, 64'h0000_0000_0000_0004);
    chk("s1.cnt", {62'd0, cnt_o}, 64'd2);
    chk("s1.acc_stall", {63'd0, stallreq_o}, 64'd0);
    aluop_i = NOP_OP;
    tick();
    chk_zero("s1.after");

    // MSUBU 0 - 0xFFFFFFFF^2 = 0x00000001_FFFFFFFF
    start_op(EXE_MSUBU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    run_to_acc(stalls, temp);
    chk("s2.stall_cycles", 64'(stalls), 64'(EXP_STALL));
    chk("s2.temp", temp, 64'h0000_0001_FFFF_FFFF);
    chk("s2.whilo", {63'd0, whilo_o}, 64'd1);
    chk("s2.hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFF);
    aluop_i = NOP_OP;
    tick();

    // MADD (-2^31)^2 + 1
    start_op(EXE_MADD_OP, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd1);
    run_to_acc(stalls, temp);
    chk("s3.stall_cycles", 64'(stalls), 64'(EXP_STALL));
    chk("s3.whilo", {63'd0, whilo_o}, 64'd1);
    chk("s3.hilo", {hi_o, lo_o}, 64'h4000_0000_0000_0001);
    aluop_i = NOP_OP;
    tick();

    // Flush mid-operation, then a clean MADDU 2*5
    start_op(EXE_MADD_OP, 32'd7, 32'd9, 32'd0, 32'd0);
    for (int i = 0; i < ((EXP_STALL < 3) ? EXP_STALL : 3); i++) tick();
    flush_i = 1'b1;
    #1;
    chk_zero("flush.cycle");
    aluop_i = NOP_OP;
    tick();
    flush_i = 1'b0;
    #1;
    chk_zero("flush.next");
    tick();
    chk("flush.no_whilo", {63'd0, whilo_o}, 64'd0);
    start_op(EXE_MADDU_OP, 32'd2, 32'd5, 32'd0, 32'd0);
    run_to_acc(stalls, temp);
    chk("s4.stall_cycles", 64'(stalls), 64'(EXP_STALL));
    chk("s4.whilo", {63'd0, whilo_o}, 64'd1);
    chk("s4.hilo", {hi_o, lo_o}, 64'h0000_0000_0000_000A);
    aluop_i = NOP_OP;
    tick();

    // EX/MEM lost the product: cnt_i forced to 00 in ACC
    start_op(EXE_MADD_OP, 32'd1, 32'd1, 32'd0, 32'd0);
    run_to_acc(stalls, temp);
    cnt_i = 2'b00;
    #1;
    chk("lost.whilo", {63'd0, whilo_o}, 64'd0);
    chk("lost.stall", {63'd0, stallreq_o}, 64'd0);
    chk("lost.hilo", {hi_o, lo_o}, 64'd0);
    aluop_i = NOP_OP;
    tick();
    chk_zero("lost.next");

    // Reset in the middle of an operation
    start_op(EXE_MADD_OP, 32'd4, 32'd4, 32'd0, 32'd0);
    tick();
    rst = 1'b1;
    aluop_i = NOP_OP;
    tick();
    rst = 1'b0;
    #1;
    chk_zero("rst_mid");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
